softmax_seq_ctrl: RTL and testbench
===================================

# softmax_seq_ctrl

Sequencer that feeds the N-wide combinational softmax datapath from a one-element-per-cycle stream and returns the normalized vector the same way. It buffers one vector, tracks its running maximum, presents max-subtracted (numerically stable) operands to the datapath for one evaluation cycle, and captures the result. The captured vector is then drained in order with valid/ready backpressure. It sits between the attention-score stream and the softmax datapath instance.

## Interface
- N, 4: vector length, equal to the datapath's N; N ≥ 2.
- DW, 16: element width, Q8.8 signed.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  controller accepts an element this cycle.
- in_data  in  DW  input element x, Q8.8.
- out_valid  out  1  output element valid.
- out_ready  in  1  consumer accepts the output element.
- out_data  out  DW  normalized element y, Q8.8.
- out_last  out  1  high with the N-th output element.
- busy  out  1  high in EVAL and DRAIN.
- sm_x  out  N×DW  operand array driven to the datapath x ports.
- sm_y  in  N×DW  result array from the datapath y ports.

## Operation
- Three states: LOAD → EVAL → DRAIN → LOAD.
- LOAD:
  - in_ready = 1.
  - Each handshake (in_valid & in_ready) writes xbuf[cnt] = in_data, then cnt++.
  - Element 0 loads max directly; later elements set max = signed max(max, in_data).
  - The handshake at cnt = N−1 moves to EVAL and clears cnt.
- EVAL (exactly 1 cycle):
  - in_ready = 0.
  - sm_x[i] = sat(xbuf[i] − max), computed at DW+1 bits; the result is always ≤ 0.
  - Any value below −32768 saturates to 0x8000.
  - At the cycle end, ybuf[i] = sm_y[i] for all i. State → DRAIN, idx = 0.
- In all states other than EVAL, sm_x is driven all zero.
- DRAIN:
  - out_valid = 1, out_data = ybuf[idx], out_last = (idx == N−1).
  - Each handshake (out_valid & out_ready) increments idx.
  - The handshake with out_last moves to LOAD, with cnt = 0 and max re-armed.
- ybuf and xbuf are not cleared between vectors. Only cnt and idx govern validity.
- The datapath is purely combinational. The controller adds no wait states beyond EVAL.

## Timing
- Reset, asynchronous assert:
  - State = LOAD, cnt = idx = 0, max = 0x8000, xbuf = ybuf = 0.
  - Outputs: in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, busy = 0, sm_x = 0.
- Latency: last input handshake at cycle t → EVAL at t+1 → first out_valid at t+2.
- Throughput: back-to-back vectors cost N + 1 + N cycles with no stalls. LOAD is re-entered the cycle after the last output handshake, so in_ready = 1 that cycle.
- in_ready is a function of state only. It does not depend on in_valid.
- Under backpressure (out_valid = 1, out_ready = 0), out_data and out_last hold stable.
- in_valid gaps in LOAD hold cnt and max.
- in_valid during EVAL or DRAIN is ignored; no element is consumed.
- Reset mid-vector (any state) aborts the vector with no partial output. The first vector after reset starts at element 0.

## Test plan
- Reset: assert rst_n = 0 mid-DRAIN, then release → out_valid = 0, in_ready = 1, busy = 0, sm_x = 0. The next vector loads from element 0.
- Stable shift, using an echo stub (sm_y = sm_x), N = 4:
  - Input {0x0200, 0xFF00, 0x0080, 0x0300}.
  - Required in the EVAL cycle: sm_x = {0xFF00, 0xFC00, 0xFD80, 0x0000}.
  - Required output stream: the same four values, out_last on the 4th.
- Saturation: input {0x8000, 0x7FFF, 0x0000, 0x7FFF} → sm_x = {0x8000, 0x0000, 0x8001, 0x0000}.
- Real datapath: input {0x0100, 0x0100, 0x0100, 0x0100} → sm_x all 0 → outputs 0x0040 ×4. The first out_valid occurs 2 cycles after the 4th handshake.
- Backpressure and flow control:
  - Hold out_ready = 0 for 3 cycles on element 1 → out_data is stable and idx does not advance.
  - Drive in_valid = 1 throughout → no element is accepted while busy = 1.
  - Insert in_valid gaps during LOAD → the resulting sm_x is identical to the gap-free case.
- Back-to-back: two vectors with in_valid and out_ready held at 1 → the second vector's first in_ready comes the cycle after the first vector's out_last handshake. Total = 18 cycles for N = 4.

Source files
------------

// File: rtl/softmax_seq_ctrl.sv
// softmax_seq_ctrl
//   Sequencer for the N-wide combinational softmax datapath. It collects one
//   vector from a one-element-per-cycle input stream and tracks the running
//   maximum. For a single EVAL cycle it presents max-subtracted, saturated
//   operands on sm_x and captures sm_y. It then streams the captured result
//   out one element per handshake.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input element handshake, in_data is Q8.8 signed
//   out_valid/out_ready   output element handshake, out_data is Q8.8 signed
//   out_last              marks the N-th output element
//   busy                  high while evaluating or draining
//   sm_x                  operands to the datapath, element i at [i*DW +: DW]
//   sm_y                  results from the datapath, same packing
`timescale 1ns/1ps
module softmax_seq_ctrl #(
  parameter int N  = 4,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic            busy,
  output logic [N*DW-1:0] sm_x,
  input  logic [N*DW-1:0] sm_y
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic signed [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};

  typedef enum logic [1:0] {S_LOAD, S_EVAL, S_DRAIN} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        idx;
  logic signed [DW-1:0] max_v;
  logic signed [DW-1:0] xbuf [N];
  logic signed [DW-1:0] ybuf [N];

  // a - b at DW+1 bits, clamped back to DW bits. With b = running max the
  // difference is never positive, so only the negative clamp is ever taken.
  function automatic logic signed [DW-1:0] sat_sub(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
    logic signed [DW:0] d;
    d = {a[DW-1], a} - {b[DW-1], b};
    if (d[DW] != d[DW-1]) begin
      sat_sub = d[DW] ? MIN_V : MAX_V;
    end else begin
      sat_sub = d[DW-1:0];
    end
  endfunction

  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_DRAIN);
  assign busy      = (state != S_LOAD);
  assign out_data  = out_valid ? ybuf[idx] : '0;
  assign out_last  = out_valid && (idx == LAST);

  // Operands are only presented during EVAL; the datapath sees zeros otherwise.
  always_comb begin
    sm_x = '0;
    if (state == S_EVAL) begin
      for (int i = 0; i < N; i++) begin
        sm_x[i*DW +: DW] = sat_sub(xbuf[i], max_v);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOAD;
      cnt   <= '0;
      idx   <= '0;
      max_v <= MIN_V;
      for (int i = 0; i < N; i++) begin
        xbuf[i] <= '0;
        ybuf[i] <= '0;
      end
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            xbuf[cnt] <= in_data;
            // Element 0 seeds the maximum so a previous vector never leaks in.
            if ((cnt == '0) || ($signed(in_data) > max_v)) begin
              max_v <= in_data;
            end
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= S_EVAL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_EVAL: begin
          for (int i = 0; i < N; i++) begin
            ybuf[i] <= sm_y[i*DW +: DW];
          end
          idx   <= '0;
          state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (idx == LAST) begin
              idx   <= '0;
              cnt   <= '0;
              max_v <= MIN_V;
              state <= S_LOAD;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
`timescale 1ns/1ps
module tb_softmax_seq_ctrl;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int W  = N * DW;

  typedef logic [W-1:0] pvec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  pvec_t         sm_x;
  pvec_t         sm_y;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int dp_mode = 0;  // 0: echo stub, 1: real-valued softmax stub

  always #5 clk = ~clk;

  softmax_seq_ctrl #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .sm_x      (sm_x),
    .sm_y      (sm_y)
  );

  // Softmax in floating point, rounded to Q8.8.
  function automatic pvec_t softmax_ref(input pvec_t x);
    real   e [N];
    real   s;
    int    q;
    pvec_t r;
    s = 0.0;
    r = '0;
    for (int i = 0; i < N; i++) begin
      e[i] = $exp($itor($signed(x[i*DW +: DW])) / 256.0);
      s += e[i];
    end
    for (int i = 0; i < N; i++) begin
      q = $rtoi(256.0 * e[i] / s + 0.5);
      r[i*DW +: DW] = q[DW-1:0];
    end
    return r;
  endfunction

  assign sm_y = (dp_mode == 1) ? softmax_ref(sm_x) : sm_x;

  // Expected operands: each element minus the vector maximum, floored at -2^(DW-1).
  function automatic pvec_t model_smx(input pvec_t x);
    int    mx;
    int    d;
    pvec_t r;
    r  = '0;
    mx = $signed(x[0 +: DW]);
    for (int i = 1; i < N; i++) begin
      if ($signed(x[i*DW +: DW]) > mx) mx = $signed(x[i*DW +: DW]);
    end
    for (int i = 0; i < N; i++) begin
      d = $signed(x[i*DW +: DW]) - mx;
      if (d < -(1 << (DW-1))) d = -(1 << (DW-1));
      r[i*DW +: DW] = d[DW-1:0];
    end
    return r;
  endfunction

  function automatic pvec_t rand_vec();
    pvec_t   r;
    logic [DW-1:0] e;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 4))
        0:       e = 16'h8000;
        1:       e = 16'h7FFF;
        default: e = DW'($urandom);
      endcase
      r[i*DW +: DW] = e;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input pvec_t got, input pvec_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  W'(in_ready),  W'(1'b1));
    chk({tag, "_out_valid"}, W'(out_valid), W'(1'b0));
    chk({tag, "_out_data"},  W'(out_data),  W'(0));
    chk({tag, "_out_last"},  W'(out_last),  W'(1'b0));
    chk({tag, "_busy"},      W'(busy),      W'(1'b0));
    chk({tag, "_sm_x"},      sm_x,          '0);
  endtask

  // One full vector: load (optionally with gaps), EVAL, drain (with optional
  // backpressure). bp: 0 none, 1 random, 2 stall element 1 for 3 cycles.
  // abort_at >= 0 asserts reset in the drain cycle presenting that element.
  task automatic run_vector(input pvec_t v, input int gaps, input int bp,
                            input int mode, input int abort_at);
    pvec_t ex, ey;
    int k, j, guard, hold;
    dp_mode = mode;
    ex = model_smx(v);
    ey = (mode == 1) ? softmax_ref(ex) : ex;

    k = 0; guard = 0;
    while (k < N) begin
      @(negedge clk); cyc++;
      in_valid = (gaps != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? v[k*DW +: DW] : DW'($urandom);
      #1;
      chk("load_in_ready",  W'(in_ready),  W'(1'b1));
      chk("load_busy",      W'(busy),      W'(1'b0));
      chk("load_out_valid", W'(out_valid), W'(1'b0));
      chk("load_sm_x",      sm_x,          '0);
      if (in_valid) k++;
      guard++;
      if (guard > 200) begin chk("load_timeout", W'(0), W'(1)); return; end
    end

    // EVAL: inputs keep arriving but must be ignored.
    @(negedge clk); cyc++;
    in_valid = 1'b1; in_data = DW'($urandom);
    #1;
    chk("eval_sm_x",      sm_x,          ex);
    chk("eval_in_ready",  W'(in_ready),  W'(1'b0));
    chk("eval_busy",      W'(busy),      W'(1'b1));
    chk("eval_out_valid", W'(out_valid), W'(1'b0));

    j = 0; hold = 0; guard = 0;
    while (j < N) begin
      @(negedge clk); cyc++;
      in_valid = 1'b1; in_data = DW'($urandom);
      if (abort_at == j) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      case (bp)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 1) == 1);
        default: begin
          out_ready = !(j == 1 && hold < 3);
          if (j == 1) hold++;
        end
      endcase
      #1;
      chk("drain_out_valid", W'(out_valid), W'(1'b1));
      chk("drain_out_data",  W'(out_data),  W'(ey[j*DW +: DW]));
      chk("drain_out_last",  W'(out_last),  W'(j == N-1));
      chk("drain_in_ready",  W'(in_ready),  W'(1'b0));
      chk("drain_busy",      W'(busy),      W'(1'b1));
      chk("drain_sm_x",      sm_x,          '0);
      if (out_ready) j++;
      guard++;
      if (guard > 200) begin chk("drain_timeout", W'(0), W'(1)); return; end
    end
  endtask

  localparam pvec_t V_SHIFT = {16'h0300, 16'h0080, 16'hFF00, 16'h0200};
  localparam pvec_t V_SAT   = {16'h7FFF, 16'h0000, 16'h7FFF, 16'h8000};
  localparam pvec_t V_ONES  = {16'h0100, 16'h0100, 16'h0100, 16'h0100};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_vector(V_SHIFT, 0, 0, 0, -1);
    run_vector(V_SAT,   0, 0, 0, -1);
    run_vector(V_ONES,  0, 0, 1, -1);
    run_vector(V_SHIFT, 1, 2, 0, -1);
    run_vector(V_SAT,   0, 0, 0, 2);
    run_vector(V_SHIFT, 0, 0, 0, -1);

    cyc = 0;
    run_vector(rand_vec(), 0, 0, 0, -1);
    run_vector(rand_vec(), 0, 0, 1, -1);
    chk("b2b_cycles", W'(cyc), W'(18));

    for (int r = 0; r < 24; r++) begin
      run_vector(rand_vec(), int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
